// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg: FSM encoding, skid sizing and reset values shared
// by ram_burst_master and ram_rd_skid.
package ram_burst_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN
  } state_e;

  localparam int SKID_DEPTH = 3;
  localparam int SKID_CW = $clog2(SKID_DEPTH + 1);
  localparam int SKID_PW = $clog2(SKID_DEPTH);

  localparam state_e RST_STATE = S_IDLE;
  localparam logic RST_PULSE = 1'b0;

  function automatic logic [SKID_PW-1:0] skid_inc(
    input logic [SKID_PW-1:0] p
  );
    return (p == SKID_PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/ram_rd_skid.sv
// ram_rd_skid: 3-entry FIFO between RAM dout and the rd stream.
// Ports: clk, rst_n, push/din (RAM side), pop (rd_ready), dout/valid, count.
module ram_rd_skid
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic [SKID_CW-1:0]    count
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [SKID_PW-1:0] wptr, rptr;
  logic pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  // Empty FIFO presents zero so rd_data has a defined reset value.
  assign dout   = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= skid_inc(wptr);
      if (pop_ok) rptr <= skid_inc(rptr);
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a 1-cycle-latency sync RAM.
// Ports: cmd_*, wr_* stream, rd_* stream, busy/done/err, ram_*. Macro: RAM_BURST_WRAP_EN.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_e state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx, rd_addr_q;
  logic [LEN_WIDTH-1:0] rem;
  logic iss_q, dv_q, done_q, err_q;
  logic [SKID_CW-1:0] sk_cnt;
  logic [2:0] outst;
  logic cmd_hs, cmd_bad, wr_hs, rd_hs, issue, last;

  assign cmd_hs = cmd_valid && (state == S_IDLE);
  assign wr_hs  = wr_valid && (state == S_WRITE);
  assign rd_hs  = rd_valid && rd_ready;
  assign last   = (rem == LEN_WIDTH'(1));

`ifdef RAM_BURST_WRAP_EN
  assign cmd_bad = (cmd_len == '0) || (32'(cmd_len) > DEPTH);
  assign addr_nx = (32'(addr) == DEPTH - 1) ? '0 : addr + 1'b1;
`else
  assign cmd_bad = (cmd_len == '0) ||
                   (32'(cmd_addr) + 32'(cmd_len) > DEPTH);
  assign addr_nx = addr + 1'b1;
`endif

  // Words issued but not yet popped: address stage, RAM stage, skid.
  assign outst = 3'(sk_cnt) + 3'(iss_q) + 3'(dv_q);
  // A pop this cycle frees a slot, keeping 1 word/cycle streaming.
  assign issue = (state == S_READ) &&
                 ((outst < 3'(SKID_DEPTH)) || rd_hs);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == S_IDLE:
        if (cmd_hs && !cmd_bad)
          state_nx = cmd_write ? S_WRITE : S_READ;
      state == S_WRITE:
        if (wr_hs && last) state_nx = S_IDLE;
      state == S_READ:
        if (issue && last) state_nx = S_DRAIN;
      state == S_DRAIN:
        if (outst == 3'd0 || (outst == 3'd1 && rd_hs))
          state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = rd_addr_q;
    ram_din   = '0;
    unique case (1'b1)
      state == S_IDLE: cmd_ready = 1'b1;
      state == S_WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        ram_addr = addr;
        if (wr_valid) ram_din = wr_data;
      end
      default: ;
    endcase
  end

  // Read addresses are registered, so RAM data lands one stage later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      rem       <= '0;
      rd_addr_q <= '0;
      iss_q     <= 1'b0;
      dv_q      <= 1'b0;
      done_q    <= RST_PULSE;
      err_q     <= RST_PULSE;
    end else begin
      iss_q  <= issue;
      dv_q   <= iss_q;
      err_q  <= cmd_hs && cmd_bad;
      done_q <= (wr_hs && last) ||
                (state == S_DRAIN && state_nx == S_IDLE);
      if (cmd_hs && !cmd_bad) begin
        addr <= cmd_addr;
        rem  <= cmd_len;
      end else if (wr_hs || issue) begin
        addr <= addr_nx;
        rem  <= rem - 1'b1;
      end
      if (issue) rd_addr_q <= addr;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

  ram_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dv_q),
    .din   (ram_dout),
    .pop   (rd_ready),
    .dout  (rd_data),
    .valid (rd_valid),
    .count (sk_cnt)
  );

endmodule
